// File: rtl/bru_pkg.sv
// Branch resolve unit shared types.
// Prediction/update entries and next-PC helper.
package bru_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } pred_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } upd_entry_t;

    function automatic logic [XLEN-1:0] next_pc(
        input logic            taken,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] tgt
    );
        return taken ? tgt : pc + PC_STEP;
    endfunction

endpackage

// File: rtl/bru_if.sv
// Fetch / execute / redirect / training bundle.
// slave = resolve unit, master = pipeline side.
interface bru_if #(
    parameter int CNT_W = 32
) ();

    logic                      i_fetch_valid;
    logic [bru_pkg::XLEN-1:0]  i_pc_F;
    logic                      i_pred_taken_F;
    logic [bru_pkg::XLEN-1:0]  i_pred_target_F;
    logic                      o_q_full;

    logic                      i_ex_valid;
    logic [bru_pkg::XLEN-1:0]  i_ex_pc;
    logic                      i_ex_is_branch;
    logic                      i_ex_is_jump;
    logic                      i_ex_taken;
    logic [bru_pkg::XLEN-1:0]  i_ex_target;

    logic                      o_redirect;
    logic [bru_pkg::XLEN-1:0]  o_redirect_pc;
    logic                      o_flush_D;
    logic                      o_flush_E;

    logic                      o_upd_valid;
    logic                      i_upd_ready;
    logic [bru_pkg::XLEN-1:0]  o_upd_pc;
    logic                      o_upd_taken;
    logic [bru_pkg::XLEN-1:0]  o_upd_target;

    logic [CNT_W-1:0]          o_br_cnt;
    logic [CNT_W-1:0]          o_mis_cnt;
    logic                      o_err;

    modport slave (
        input  i_fetch_valid, i_pc_F, i_pred_taken_F, i_pred_target_F,
        input  i_ex_valid, i_ex_pc, i_ex_is_branch, i_ex_is_jump,
        input  i_ex_taken, i_ex_target, i_upd_ready,
        output o_q_full, o_redirect, o_redirect_pc, o_flush_D, o_flush_E,
        output o_upd_valid, o_upd_pc, o_upd_taken, o_upd_target,
        output o_br_cnt, o_mis_cnt, o_err
    );

    modport master (
        output i_fetch_valid, i_pc_F, i_pred_taken_F, i_pred_target_F,
        output i_ex_valid, i_ex_pc, i_ex_is_branch, i_ex_is_jump,
        output i_ex_taken, i_ex_target, i_upd_ready,
        input  o_q_full, o_redirect, o_redirect_pc, o_flush_D, o_flush_E,
        input  o_upd_valid, o_upd_pc, o_upd_taken, o_upd_target,
        input  o_br_cnt, o_mis_cnt, o_err
    );

endinterface

// File: rtl/bru_fifo.sv
// Synchronous FIFO with flush; push is accepted
// when full only if a pop happens in the same cycle.
module bru_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves fetch-time predictions in execute, drives
// redirect/flush, perf counters and predictor training.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int UPD_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input logic i_clk,
    input logic i_rst,
    bru_if.slave bus
);

    pred_entry_t q_din;
    pred_entry_t q_head;
    logic        q_full;
    logic        q_empty;
    logic [$clog2(QDEPTH):0] q_cnt_unused;

    upd_entry_t  upd_din;
    upd_entry_t  upd_head;
    logic        upd_full;
    logic        upd_empty;
    logic [$clog2(UPD_DEPTH):0] upd_cnt_unused;

    logic            pop_ok;
    logic            is_cf;
    logic            act_taken;
    logic [XLEN-1:0] act_next;
    logic [XLEN-1:0] pred_next;
    logic            mispred;
    logic            upd_push;
    logic            upd_drop;
    logic            err_set;

    logic             redirect_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;
    logic             err_q;

    assign q_din = '{
        pc:          bus.i_pc_F,
        pred_taken:  bus.i_pred_taken_F,
        pred_target: bus.i_pred_target_F
    };

    assign pop_ok    = bus.i_ex_valid & ~q_empty;
    assign is_cf     = bus.i_ex_is_branch | bus.i_ex_is_jump;
    assign act_taken = bus.i_ex_is_jump
                     | (bus.i_ex_is_branch & bus.i_ex_taken);
    assign act_next  = next_pc(act_taken, bus.i_ex_pc, bus.i_ex_target);
    assign pred_next = next_pc(q_head.pred_taken, q_head.pc,
                               q_head.pred_target);
    assign mispred   = pop_ok & (act_next != pred_next);

    assign upd_din  = '{
        pc:     bus.i_ex_pc,
        taken:  act_taken,
        target: bus.i_ex_target
    };
    assign upd_push = pop_ok & is_cf;
    assign upd_drop = upd_push & upd_full & ~bus.i_upd_ready;

    assign err_set = (bus.i_ex_valid & q_empty)
                   | (bus.i_fetch_valid & q_full & ~pop_ok)
                   | (pop_ok & (q_head.pc != bus.i_ex_pc))
                   | upd_drop;

    // A mispredicting pop wipes younger wrong-path entries on the
    // same edge, so a push offered alongside it is discarded.
    bru_fifo #(
        .T     (pred_entry_t),
        .DEPTH (QDEPTH)
    ) u_pred_q (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .flush (mispred),
        .push  (bus.i_fetch_valid),
        .pop   (bus.i_ex_valid),
        .din   (q_din),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_cnt_unused)
    );

    // Training updates survive redirects.
    bru_fifo #(
        .T     (upd_entry_t),
        .DEPTH (UPD_DEPTH)
    ) u_upd_q (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .flush (1'b0),
        .push  (upd_push),
        .pop   (bus.i_upd_ready),
        .din   (upd_din),
        .dout  (upd_head),
        .full  (upd_full),
        .empty (upd_empty),
        .count (upd_cnt_unused)
    );

    // Redirect pulse, saturating counters and sticky error.
    // Only control-flow mispredicts count toward o_mis_cnt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            redirect_q <= mispred;
            if (mispred) begin
                redirect_pc_q <= act_next;
            end
            if (upd_push && !(&br_cnt_q)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mispred && is_cf && !(&mis_cnt_q)) begin
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.o_q_full      = q_full;
    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_flush_D     = redirect_q;
    assign bus.o_flush_E     = redirect_q;
    assign bus.o_upd_valid   = ~upd_empty;
    assign bus.o_upd_pc      = upd_head.pc;
    assign bus.o_upd_taken   = upd_head.taken;
    assign bus.o_upd_target  = upd_head.target;
    assign bus.o_br_cnt      = br_cnt_q;
    assign bus.o_mis_cnt     = mis_cnt_q;
    assign bus.o_err         = err_q;

endmodule
